// File: rtl/mod_dec_inv_mix_columns.sv
// rtl/mod_dec_inv_mix_columns.sv - AES InvMixColumns stage, one column per clock.
// INV_MC_UNROLL_EN: compute all four columns on the edge after accept.
module mod_dec_inv_mix_columns #(
  localparam int N = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0][7:0] inp_imc,
  input  logic              in_bypass,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0][7:0] outp_imc
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state;
  logic [N-1:0][7:0]   src;
  logic [N-1:0][7:0]   res;
  logic                bypass;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [3:0][7:0] inv_col(input logic [3:0][7:0] x);
    logic [3:0][7:0] x2, x4, x8, m9, mb, md, me, y;
    for (int i = 0; i < 4; i++) begin
      x2[i] = xtime(x[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ x[i];
      mb[i] = x8[i] ^ x2[i] ^ x[i];
      md[i] = x8[i] ^ x4[i] ^ x[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    y[0] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
    y[1] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
    y[2] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
    y[3] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    return y;
  endfunction

`ifdef INV_MC_UNROLL_EN
  logic [N-1:0][7:0] full;

  always_comb begin
    full = '0;
    for (int c = 0; c < 4; c++) begin
      full[c*4 +: 4] = inv_col(src[c*4 +: 4]);
    end
  end
`else
  logic [1:0]        col;
  logic [3:0][7:0]   cur_col;
  logic [3:0][7:0]   mixed;

  // Column selector into src; the byte index is {col, row}.
  always_comb begin
    cur_col = '0;
    for (int r = 0; r < 4; r++) begin
      cur_col[r] = src[{col, 2'(r)}];
    end
    mixed = inv_col(cur_col);
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      src       <= '0;
      res       <= '0;
      bypass    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
`ifndef INV_MC_UNROLL_EN
      col       <= 2'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            src      <= inp_imc;
            res      <= inp_imc;
            bypass   <= in_bypass;
            in_ready <= 1'b0;
            state    <= BUSY;
`ifndef INV_MC_UNROLL_EN
            col      <= 2'd0;
`endif
          end
        end
        BUSY: begin
`ifdef INV_MC_UNROLL_EN
          if (!bypass) res <= full;
          state     <= DONE;
          out_valid <= 1'b1;
`else
          // Bypass leaves res == src but still walks all four columns.
          if (!bypass) begin
            for (int r = 0; r < 4; r++) begin
              res[{col, 2'(r)}] <= mixed[r];
            end
          end
          col <= col + 2'd1;
          if (col == 2'd3) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
`endif
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign outp_imc = res;

endmodule

// File: tb/tb_mod_dec_inv_mix_columns.sv
// tb/tb_mod_dec_inv_mix_columns.sv - directed and round-trip bench for mod_dec_inv_mix_columns.
module tb_mod_dec_inv_mix_columns;

  typedef logic [15:0][7:0] st_t;

`ifdef INV_MC_UNROLL_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 4;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  st_t  inp_imc = '0;
  logic in_bypass = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  st_t  outp_imc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod_dec_inv_mix_columns dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .inp_imc(inp_imc), .in_bypass(in_bypass), .out_valid(out_valid),
    .out_ready(out_ready), .outp_imc(outp_imc)
  );

  // Columns given as 32-bit words, row 0 in the top byte.
  function automatic st_t mk(input logic [31:0] c0, c1, c2, c3);
    st_t s;
    logic [3:0][31:0] w;
    w = {c3, c2, c1, c0};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[c*4+r] = w[c][31-8*r -: 8];
    return s;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward MixColumns, used only to build round-trip stimulus.
  function automatic st_t fwd_mix(input st_t s);
    st_t o;
    for (int c = 0; c < 4; c++) begin
      logic [7:0] a, b, d, e;
      a = s[c*4]; b = s[c*4+1]; d = s[c*4+2]; e = s[c*4+3];
      o[c*4]   = xt(a) ^ xt(b) ^ b ^ d ^ e;
      o[c*4+1] = a ^ xt(b) ^ xt(d) ^ d ^ e;
      o[c*4+2] = a ^ b ^ xt(d) ^ xt(e) ^ e;
      o[c*4+3] = xt(a) ^ a ^ b ^ d ^ xt(e);
    end
    return o;
  endfunction

  task automatic run_block(input st_t s, input logic byp, output st_t r, output int lat);
    @(negedge clk);
    in_valid = 1'b1; inp_imc = s; in_bypass = byp;
    @(posedge clk);
    #1 in_valid = 1'b0; inp_imc = '0; in_bypass = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
    end
    r = outp_imc;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (outp_imc !== '0) begin errors++; $display("FAIL reset_outp got %h want 0", outp_imc); end
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_mix_vectors();
    st_t r, e;
    int lat;
    run_block(mk(32'h8e4da1bc, 32'h01010101, 32'h01010101, 32'h01010101), 1'b0, r, lat);
    e = mk(32'hdb135345, 32'h01010101, 32'h01010101, 32'h01010101);
    checks++;
    if (r !== e) begin errors++; $display("FAIL mix_vec1 got %h want %h", r, e); end
    checks++;
    if (lat !== EXP_LAT) begin errors++; $display("FAIL mix_vec1_latency got %0d want %0d", lat, EXP_LAT); end
    run_block(mk(32'h9fdc589d, 32'hd5d5d7d6, 32'h4d7ebdf8, 32'hc6c6c6c6), 1'b0, r, lat);
    e = mk(32'hf20a225c, 32'hd4d4d4d5, 32'h2d26314c, 32'hc6c6c6c6);
    checks++;
    if (r !== e) begin errors++; $display("FAIL mix_vec2 got %h want %h", r, e); end
    checks++;
    if (lat !== EXP_LAT) begin errors++; $display("FAIL mix_vec2_latency got %0d want %0d", lat, EXP_LAT); end
  endtask

  task automatic test_bypass();
    st_t r, s;
    int lat;
    s = mk(32'h8e4da1bc, 32'h01010101, 32'h01010101, 32'h01010101);
    run_block(s, 1'b1, r, lat);
    checks++;
    if (r !== s) begin errors++; $display("FAIL bypass_data got %h want %h", r, s); end
    checks++;
    if (lat !== EXP_LAT) begin errors++; $display("FAIL bypass_latency got %0d want %0d", lat, EXP_LAT); end
  endtask

  task automatic test_hold();
    st_t e, held;
    int lat;
    e = mk(32'hdb135345, 32'h01010101, 32'h01010101, 32'h01010101);
    @(negedge clk);
    in_valid = 1'b1;
    inp_imc = mk(32'h8e4da1bc, 32'h01010101, 32'h01010101, 32'h01010101);
    @(posedge clk);
    #1 in_valid = 1'b0; inp_imc = '0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (out_valid) break;
    end
    checks++;
    if (lat !== EXP_LAT) begin errors++; $display("FAIL hold_latency got %0d want %0d", lat, EXP_LAT); end
    held = outp_imc;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        in_valid = 1'b1;
        inp_imc = mk(32'h9fdc589d, 32'hd5d5d7d6, 32'h4d7ebdf8, 32'hc6c6c6c6);
      end else begin
        in_valid = 1'b0;
        inp_imc = '0;
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || outp_imc !== held) begin
        errors++;
        $display("FAIL hold_stable cycle %0d got valid=%b ready=%b data=%h want valid=1 ready=0 data=%h",
                 i, out_valid, in_ready, outp_imc, held);
      end
    end
    in_valid = 1'b0; inp_imc = '0;
    checks++;
    if (held !== e) begin errors++; $display("FAIL hold_data got %h want %h", held, e); end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_ignored_input got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_mid_reset();
    st_t r, e;
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    inp_imc = mk(32'h8e4da1bc, 32'h01010101, 32'h01010101, 32'h01010101);
    @(posedge clk);
    #1 in_valid = 1'b0; inp_imc = '0;
    @(posedge clk);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || outp_imc !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset got valid=%b ready=%b data=%h want valid=0 ready=1 data=0",
               out_valid, in_ready, outp_imc);
    end
    @(negedge clk);
    resetn = 1'b1;
    run_block(mk(32'h9fdc589d, 32'hd5d5d7d6, 32'h4d7ebdf8, 32'hc6c6c6c6), 1'b0, r, lat);
    e = mk(32'hf20a225c, 32'hd4d4d4d5, 32'h2d26314c, 32'hc6c6c6c6);
    checks++;
    if (r !== e || lat !== EXP_LAT) begin
      errors++;
      $display("FAIL after_reset got %h lat %0d want %h lat %0d", r, lat, e, EXP_LAT);
    end
  endtask

  task automatic test_round_trip();
    st_t orig, r;
    int lat;
    for (int n = 0; n < 1000; n++) begin
      orig = {$urandom, $urandom, $urandom, $urandom};
      run_block(fwd_mix(orig), 1'b0, r, lat);
      checks++;
      if (r !== orig) begin
        errors++;
        $display("FAIL round_trip vec %0d got %h want %h", n, r, orig);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mix_vectors();
    test_bypass();
    test_hold();
    test_mid_reset();
    test_round_trip();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_dec_inv_mix_columns.md
# mod_dec_inv_mix_columns

Iterative AES-256 InvMixColumns stage for the decryption datapath, mirroring the encryption-side MixColumns stage. It accepts a 16-byte state over a valid/ready handshake and multiplies each column by the inverse MixColumns matrix over GF(2^8). It processes one column per clock and returns the result over a second valid/ready handshake. It sits between InvShiftRows/InvSubBytes and AddRoundKey in the decryption round pipeline.

## Interface

- N, 16, state width in bytes; fixed, not overridable.
- clk  input  1  clock, rising edge.
- resetn  input  1  reset, asynchronous, active-low.
- in_valid  input  1  inp_imc and in_bypass are valid.
- in_ready  output  1  block can accept a state.
- inp_imc  input  [N-1:0][7:0]  input state; byte c*4+r is column c, row r.
- in_bypass  input  1  final decryption round: pass the state through unmodified.
- out_valid  output  1  outp_imc holds a completed result.
- out_ready  input  1  downstream accepts the result.
- outp_imc  output  [N-1:0][7:0]  output state, same byte ordering as inp_imc.

## Operation

- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch inp_imc into src, latch in_bypass, clear col, load res with src, go to BUSY.
- BUSY, each edge:
  - Compute column col of src into res bytes col*4..col*4+3, then increment col.
  - When col==3: go to DONE and set out_valid=1.
  - When bypass is latched: res is left equal to src, but the FSM still spends the same 4 cycles.
- Column math, with a..d = rows 0..3:
  - r0 = 0e·a ^ 0b·b ^ 0d·c ^ 09·d
  - r1 = 09·a ^ 0e·b ^ 0b·c ^ 0d·d
  - r2 = 0d·a ^ 09·b ^ 0e·c ^ 0b·d
  - r3 = 0b·a ^ 0d·b ^ 09·c ^ 0e·d
- GF multiplies are built from xtime:
  - xtime(x) = (x<<1) ^ (x[7] ? 8'h1b : 0), truncated to 8 bits.
  - 09 = x8^x; 0b = x8^x2^x; 0d = x8^x4^x; 0e = x8^x4^x2, where x2/x4/x8 are chained xtime.
- DONE:
  - out_valid=1, outp_imc=res, held stable until out_ready.
  - On out_ready: out_valid drops and the FSM returns to IDLE.
- in_ready is 1 only in IDLE; in_valid outside IDLE is ignored.
- outp_imc always reflects res; its value is valid only while out_valid=1.
- Reset, asynchronous at any time including mid-BUSY:
  - state=IDLE, col=0, src=0, res=0, bypass=0.
  - Outputs: out_valid=0, in_ready=1 on exit from reset, outp_imc=0.
  - Any in-flight block is discarded.

## Timing

- Accept edge E0. BUSY runs on edges E1..E4. out_valid rises after E4, giving a latency of 4 cycles from accept.
- Result is consumed on the first edge with out_ready=1 while in DONE. If out_ready is already high when out_valid rises, the handshake completes on the next edge (E5).
- in_ready rises in the cycle after the output handshake. Minimum block period is 6 cycles.
- No combinational path from in_valid or out_ready to any output; all outputs are registered or state-decoded.

## Configuration

- INV_MC_UNROLL_EN defined:
  - All four columns are computed on the single edge after accept (E1).
  - out_valid rises after E1, giving 1-cycle latency. col is unused.
  - Bypass also completes in 1 cycle.
- INV_MC_UNROLL_EN undefined: iterative 4-cycle operation as described above.
- Handshake, reset and output values are identical in both builds.

## Test plan

- Column 0 = 8e 4d a1 bc, columns 1-3 = 01 01 01 01, bypass=0 -> out column 0 = db 13 53 45, other columns 01 01 01 01; out_valid asserted exactly 4 cycles after accept (1 cycle with INV_MC_UNROLL_EN).
- Columns = 9f dc 58 9d, d5 d5 d7 d6, 4d 7e bd f8, c6 c6 c6 c6 -> f2 0a 22 5c, d4 d4 d4 d5, 2d 26 31 4c, c6 c6 c6 c6.
- Same first-scenario input with in_bypass=1 -> outp_imc equals input bytes exactly, with the same latency as the non-bypass case.
- Hold out_ready=0 for 10 cycles after out_valid -> outp_imc stable, out_valid high, in_ready low; a concurrent in_valid pulse with a different state is ignored, and the next output still matches the first input.
- Assert resetn low at E2 mid-BUSY -> out_valid=0, outp_imc=0, FSM in IDLE. A new accepted state after release produces its own correct result.
- Round-trip: random 128-bit states through the encryption MixColumns stage, then this block -> output equals the original state (1000 vectors).
